// File: rtl/yolo_axis_feeder_pkg.sv
// rtl/yolo_axis_feeder_pkg.sv - shared types and defaults for the AXIS frame feeder
package yolo_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } feeder_state_t;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_LEN_W  = 20;
    localparam int DEF_GAP_W  = 8;

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/yolo_axis_feeder_if.sv
// rtl/yolo_axis_feeder_if.sv - AXI4-Stream bundle between feeder and kernel
interface yolo_axis_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/yolo_axis_feeder_fifo.sv
// rtl/yolo_axis_feeder_fifo.sv - first-word-fall-through buffer for outgoing beats
module yolo_axis_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_valid,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_push    = i_wr_valid && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/yolo_axis_feeder.sv
// rtl/yolo_axis_feeder.sv - frames buffered words onto the kernel inStream with gaps and a stall watchdog
module yolo_axis_feeder
    import yolo_axis_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int GAP_W       = DEF_GAP_W,
    parameter int FIFO_DEPTH  = 16,
    parameter int STALL_LIMIT = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    yolo_axis_if.master       m_axis,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  beat_cnt,
    output logic              stall_err
);

    localparam int KEEP_W  = keep_w(DATA_W);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    feeder_state_t       r_state;
    feeder_state_t       w_state_nxt;
    logic [LEN_W-1:0]    r_len;
    logic [GAP_W-1:0]    r_gap;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [STALL_W-1:0]  r_stall_cnt;
    logic [STALL_W-1:0]  w_stall_nxt;
    logic                r_stall_err;

    logic [DATA_W-1:0]   w_fifo_data;
    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_tvalid;
    logic                w_hs;
    logic                w_last;
    logic                w_accept;

    yolo_axis_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .i_wr_valid (wr_valid),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_hs),
        .o_rd_data  (w_fifo_data),
        .o_count    (w_fifo_count),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // tvalid comes only from state and FIFO occupancy, never from tready.
    always_comb begin
        w_state_nxt = r_state;
        w_tvalid    = (r_state == ST_SEND) && !w_fifo_empty;
        w_hs        = w_tvalid && m_axis.tready;
        w_last      = (r_beat_cnt == (r_len - LEN_W'(1)));
        w_accept    = (r_state == ST_IDLE) && start;
        busy        = (r_state == ST_SEND) || (r_state == ST_GAP);
        done        = (r_state == ST_FIN);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (frame_len != '0) ? ST_SEND : ST_FIN;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt = ST_FIN;
                    end else if (r_gap != '0) begin
                        w_state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(1)) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Starvation (tvalid low) is not the kernel's fault, so it clears the count.
    always_comb begin
        w_stall_nxt = '0;
        if (w_tvalid && !m_axis.tready) begin
            w_stall_nxt = (r_stall_cnt == STALL_W'(STALL_LIMIT)) ? r_stall_cnt
                                                                 : r_stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len       <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len      <= frame_len;
                r_gap      <= gap_cycles;
                r_beat_cnt <= '0;
            end else if (w_hs) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end

            if (w_hs && !w_last && (r_gap != '0)) begin
                r_gap_cnt <= r_gap;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end

            r_stall_cnt <= w_stall_nxt;
            if (w_accept) begin
                r_stall_err <= 1'b0;
            end else if (w_stall_nxt == STALL_W'(STALL_LIMIT)) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    assign wr_ready      = !w_fifo_full;
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_fifo_data;
    assign m_axis.tkeep  = {KEEP_W{1'b1}};
    assign m_axis.tlast  = w_tvalid && w_last;
    assign beat_cnt      = r_beat_cnt;
    assign stall_err     = r_stall_err;

    a_count_bound: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        w_fifo_count <= CNT_W'(FIFO_DEPTH));

    a_tvalid_hold: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        (w_tvalid && !m_axis.tready) |=> (w_tvalid && $stable(w_fifo_data) && $stable(m_axis.tlast)));

endmodule

// File: tb/tb_yolo_axis_feeder.sv
// tb/tb_yolo_axis_feeder.sv - scoreboard bench for the AXIS frame feeder
module tb_yolo_axis_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] frame_len;
    logic [7:0]  gap_cycles;
    logic        wr_valid;
    logic        wr_ready;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic [19:0] beat_cnt;
    logic        stall_err;

    int n_tests;
    int n_fail;

    logic [63:0] q_words [$];
    logic [64:0] exp_q   [$];

    yolo_axis_if #(.DATA_W(64)) axis_if ();

    yolo_axis_feeder #(
        .DATA_W      (64),
        .LEN_W       (20),
        .GAP_W       (8),
        .FIFO_DEPTH  (16),
        .STALL_LIMIT (8)
    ) dut (
        .ap_clk     (clk),
        .ap_rst_n   (rst_n),
        .start      (start),
        .frame_len  (frame_len),
        .gap_cycles (gap_cycles),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .m_axis     (axis_if),
        .busy       (busy),
        .done       (done),
        .beat_cnt   (beat_cnt),
        .stall_err  (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && axis_if.tvalid && axis_if.tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(axis_if.tdata), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", axis_if.tdata, e[63:0]);
                check("beat_last", 64'(axis_if.tlast), 64'(e[64]));
                check("beat_keep", 64'(axis_if.tkeep), 64'hFF);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prefill(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 64'(i) * 64'h11;
            q_words.push_back(wr_data);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic start_frame(input int len, input int gap);
        logic [63:0] w;
        for (int i = 0; i < len; i++) begin
            w = q_words.pop_front();
            exp_q.push_back({(i == len - 1), w});
        end
        start      = 1'b1;
        frame_len  = 20'(len);
        gap_cycles = 8'(gap);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        check("done_seen", 64'(done), 64'h1);
    endtask

    task automatic check_reset_vals();
        check("rst_tvalid", 64'(axis_if.tvalid), 64'h0);
        check("rst_tlast", 64'(axis_if.tlast), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_stall_err", 64'(stall_err), 64'h0);
        check("rst_beat_cnt", 64'(beat_cnt), 64'h0);
        check("rst_wr_ready", 64'(wr_ready), 64'h1);
    endtask

    initial begin
        logic [8:0] tv;
        logic [8:0] dn;
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        start          = 1'b0;
        frame_len      = '0;
        gap_cycles     = '0;
        wr_valid       = 1'b0;
        wr_data        = '0;
        axis_if.tready = 1'b1;
        repeat (3) tick();
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        // Back-to-back frame of four prefilled words.
        prefill(64'h11, 4);
        start_frame(4, 0);
        tv = '0;
        dn = '0;
        for (int i = 0; i < 6; i++) begin
            tv[i] = axis_if.tvalid;
            dn[i] = done;
            tick();
        end
        check("b2b_tvalid_pattern", 64'(tv), 64'h0F);
        check("b2b_done_pattern", 64'(dn), 64'h10);
        check("b2b_beat_cnt", 64'(beat_cnt), 64'd4);

        // Gap of two idle cycles between beats, none after the last.
        prefill(64'hA1, 3);
        start_frame(3, 2);
        tv = '0;
        dn = '0;
        for (int i = 0; i < 9; i++) begin
            tv[i] = axis_if.tvalid;
            dn[i] = done;
            tick();
        end
        check("gap_tvalid_pattern", 64'(tv), 64'h049);
        check("gap_done_pattern", 64'(dn), 64'h080);
        check("gap_beat_cnt", 64'(beat_cnt), 64'd3);

        // Backpressure: held beat stays stable, then drains without loss.
        prefill(64'hB1, 3);
        axis_if.tready = 1'b0;
        start_frame(3, 0);
        for (int i = 0; i < 5; i++) begin
            check("hold_tvalid", 64'(axis_if.tvalid), 64'h1);
            check("hold_tdata", axis_if.tdata, 64'hB1);
            check("hold_tlast", 64'(axis_if.tlast), 64'h0);
            tick();
        end
        axis_if.tready = 1'b1;
        wait_done();
        check("hold_beat_cnt", 64'(beat_cnt), 64'd3);
        check("hold_no_stall", 64'(stall_err), 64'h0);
        tick();

        // Watchdog trips on the eighth blocked cycle and is sticky.
        prefill(64'hC1, 2);
        axis_if.tready = 1'b0;
        start_frame(2, 0);
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (j == 7) check("stall_before_limit", 64'(stall_err), 64'h0);
            if (j == 8) check("stall_at_limit", 64'(stall_err), 64'h1);
        end
        tick();
        axis_if.tready = 1'b1;
        wait_done();
        check("stall_sticky", 64'(stall_err), 64'h1);
        check("stall_beat_cnt", 64'(beat_cnt), 64'd2);
        tick();

        // Zero-length frame: done next cycle, no beats, clears stall_err.
        start_frame(0, 0);
        check("len0_done", 64'(done), 64'h1);
        check("len0_tvalid", 64'(axis_if.tvalid), 64'h0);
        check("len0_busy", 64'(busy), 64'h0);
        check("len0_stall_clr", 64'(stall_err), 64'h0);
        check("len0_beat_cnt", 64'(beat_cnt), 64'd0);
        tick();
        check("len0_done_pulse", 64'(done), 64'h0);

        // A start during a busy frame is dropped.
        prefill(64'hD1, 3);
        start_frame(3, 3);
        start     = 1'b1;
        frame_len = 20'd1;
        tick();
        start = 1'b0;
        wait_done();
        check("busy_start_beat_cnt", 64'(beat_cnt), 64'd3);
        tick();
        tick();
        check("busy_start_idle", 64'(busy), 64'h0);

        // Seventeen writes into a sixteen-deep FIFO.
        axis_if.tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 64'hE0 + 64'(i);
            if (i < 16) begin
                check("fill_wr_ready", 64'(wr_ready), 64'h1);
                q_words.push_back(wr_data);
            end else begin
                check("full_wr_ready", 64'(wr_ready), 64'h0);
            end
            tick();
        end
        wr_valid = 1'b0;
        check("full_wr_ready_after", 64'(wr_ready), 64'h0);

        // Reset after two beats of an eight-beat frame.
        axis_if.tready = 1'b1;
        start_frame(8, 0);
        tick();
        tick();
        check("mid_beat_cnt", 64'(beat_cnt), 64'd2);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        q_words.delete();
        #1;
        check_reset_vals();
        tick();
        check("rst_hold_done", 64'(done), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_wr_ready", 64'(wr_ready), 64'h1);
        check("post_rst_tvalid", 64'(axis_if.tvalid), 64'h0);

        prefill(64'hF1, 2);
        start_frame(2, 0);
        wait_done();
        check("post_rst_beat_cnt", 64'(beat_cnt), 64'd2);
        tick();
        tick();
        check("post_rst_idle_tvalid", 64'(axis_if.tvalid), 64'h0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
